// File: rtl/uart_rx_cfg_if.sv
// Serial-line bundle between the host pin, the configurable UART receiver and its consumer.
// The slave modport is the receiver side; the master modport is the line driver and word consumer.
interface uart_rx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx_i;
  logic [DATA_BITS-1:0] data_o;
  logic                 valid_o;
  logic                 parity_err_o;
  logic                 frame_err_o;
  logic                 break_o;
  logic                 busy_o;

  modport slave (
    input  rx_i,
    output data_o, valid_o, parity_err_o, frame_err_o, break_o, busy_o
  );

  modport master (
    output rx_i,
    input  data_o, valid_o, parity_err_o, frame_err_o, break_o, busy_o
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-9 data bits, none/odd/even parity, 1 or 2 stop bits.
// Each word is delivered with parity, framing and line-break flags.
module uart_rx_cfg #(
  parameter int unsigned CLOCKS_PER_BAUD = 6,
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned PARITY          = 0,
  parameter int unsigned STOP_BITS       = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  uart_rx_cfg_if.slave bus
);

  localparam int unsigned CW = $clog2(CLOCKS_PER_BAUD);
  localparam int unsigned IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF      = CW'(CLOCKS_PER_BAUD / 32'd2 - 32'd1);
  localparam logic [CW-1:0] FULL      = CW'(CLOCKS_PER_BAUD - 32'd1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 32'd1);
  localparam logic          LAST_STOP = (STOP_BITS == 32'd2);
  localparam logic          HAS_PAR   = (PARITY != 32'd0);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HALFWAIT = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_PARITY   = 3'd3;
  localparam logic [2:0] ST_STOP     = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;
  localparam logic [2:0] ST_BRKWAIT  = 3'd6;

  // Parity mismatch over data plus received parity bit for the configured mode.
  function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
    logic ones_odd;
    ones_odd = ^{d, p};
    case (PARITY)
      32'd1:   return ~ones_odd;
      32'd2:   return ones_odd;
      default: return 1'b0;
    endcase
  endfunction

  logic                 rx_meta_r;
  logic                 rx_sync_r;
  logic [2:0]           state_r;
  logic [CW-1:0]        cnt_r;
  logic [IW-1:0]        bit_idx_r;
  logic                 stop_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_bit_r;
  logic                 frame_err_r;
  logic                 stop0_low_r;
  logic                 cnt_zero_s;
  logic                 brk_s;

  assign cnt_zero_s = (cnt_r == '0);
  assign brk_s      = (shift_r == '0) && (!HAS_PAR || !par_bit_r) && stop0_low_r;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= bus.rx_i;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Frame state machine, bit sampling and registered word/flag outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= ST_IDLE;
      cnt_r            <= '0;
      bit_idx_r        <= '0;
      stop_idx_r       <= 1'b0;
      shift_r          <= '0;
      par_bit_r        <= 1'b0;
      frame_err_r      <= 1'b0;
      stop0_low_r      <= 1'b0;
      bus.data_o       <= '0;
      bus.valid_o      <= 1'b0;
      bus.parity_err_o <= 1'b0;
      bus.frame_err_o  <= 1'b0;
      bus.break_o      <= 1'b0;
      bus.busy_o       <= 1'b0;
    end else begin
      bus.valid_o      <= 1'b0;
      bus.parity_err_o <= 1'b0;
      bus.frame_err_o  <= 1'b0;
      bus.break_o      <= 1'b0;
      bus.busy_o       <= (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (!rx_sync_r) begin
            state_r <= ST_HALFWAIT;
            cnt_r   <= HALF;
          end
        end
        ST_HALFWAIT: begin
          if (!cnt_zero_s) begin
            cnt_r <= cnt_r - CW'(1);
          end else if (rx_sync_r) begin
            state_r <= ST_IDLE;
          end else begin
            state_r   <= ST_DATA;
            cnt_r     <= FULL;
            bit_idx_r <= '0;
          end
        end
        ST_DATA: begin
          if (!cnt_zero_s) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            shift_r <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
            cnt_r   <= FULL;
            if (bit_idx_r == LAST_BIT) begin
              state_r     <= HAS_PAR ? ST_PARITY : ST_STOP;
              stop_idx_r  <= 1'b0;
              frame_err_r <= 1'b0;
            end else begin
              bit_idx_r <= bit_idx_r + IW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (!cnt_zero_s) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            par_bit_r <= rx_sync_r;
            cnt_r     <= FULL;
            state_r   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (!cnt_zero_s) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            cnt_r <= FULL;
            if (!rx_sync_r) begin
              frame_err_r <= 1'b1;
            end
            if (!stop_idx_r) begin
              stop0_low_r <= !rx_sync_r;
            end
            if (stop_idx_r == LAST_STOP) begin
              state_r <= ST_DONE;
            end else begin
              stop_idx_r <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          bus.data_o       <= shift_r;
          bus.valid_o      <= 1'b1;
          bus.parity_err_o <= parity_error(shift_r, par_bit_r);
          bus.frame_err_o  <= frame_err_r;
          bus.break_o      <= brk_s;
          state_r          <= brk_s ? ST_BRKWAIT : ST_IDLE;
        end
        ST_BRKWAIT: begin
          if (rx_sync_r) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 8E1 and 7O2 instances on one clock and reset,
// frames driven bit by bit with hand-computed expected words and flags.
module tb_uart_rx_cfg;
  localparam int CPB = 6;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;
  int   cyc;

  uart_rx_cfg_if #(.DATA_BITS(8)) ifa ();
  uart_rx_cfg_if #(.DATA_BITS(8)) ifb ();
  uart_rx_cfg_if #(.DATA_BITS(7)) ifc ();

  uart_rx_cfg #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut_a (.clock(clock), .reset_n(reset_n), .bus(ifa));
  uart_rx_cfg #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    dut_b (.clock(clock), .reset_n(reset_n), .bus(ifb));
  uart_rx_cfg #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2))
    dut_c (.clock(clock), .reset_n(reset_n), .bus(ifc));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Word capture per instance, sampled on the falling edge.
  int         cnt_a, cnt_b, cnt_c;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c, first_c;
  logic       perr_a, ferr_a, brk_a, perr_b, ferr_b, perr_c, ferr_c, brk_c;
  int         tlast_c, tprev_c;

  initial begin
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cyc = 0;
    tlast_c = 0; tprev_c = 0;
  end

  always @(negedge clock) begin
    if (ifa.valid_o === 1'b1) begin
      cnt_a  <= cnt_a + 1;
      data_a <= ifa.data_o;
      perr_a <= ifa.parity_err_o;
      ferr_a <= ifa.frame_err_o;
      brk_a  <= ifa.break_o;
    end
    if (ifb.valid_o === 1'b1) begin
      cnt_b  <= cnt_b + 1;
      data_b <= ifb.data_o;
      perr_b <= ifb.parity_err_o;
      ferr_b <= ifb.frame_err_o;
    end
    if (ifc.valid_o === 1'b1) begin
      cnt_c   <= cnt_c + 1;
      data_c  <= ifc.data_o;
      perr_c  <= ifc.parity_err_o;
      ferr_c  <= ifc.frame_err_o;
      brk_c   <= ifc.break_o;
      tprev_c <= tlast_c;
      tlast_c <= cyc;
      if (cnt_c == 0) first_c <= ifc.data_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold the selected line at v for n clock cycles, changing just after a rising edge.
  task automatic drive(input int sel, input logic v, input int n);
    case (sel)
      0:       ifa.rx_i = v;
      1:       ifb.rx_i = v;
      default: ifc.rx_i = v;
    endcase
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // bits[0] is the start bit, transmitted first.
  task automatic send(input int sel, input logic [15:0] bits, input int len);
    for (int i = 0; i < len; i++) drive(sel, bits[i], CPB);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0;
    ifa.rx_i = 1'b1; ifb.rx_i = 1'b1; ifc.rx_i = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_data_a",  {24'd0, ifa.data_o}, 32'h0);
    chk("rst_valid_a", {31'd0, ifa.valid_o}, 32'h0);
    chk("rst_busy_a",  {31'd0, ifa.busy_o}, 32'h0);
    chk("rst_flags_b", {29'd0, ifb.parity_err_o, ifb.frame_err_o, ifb.break_o}, 32'h0);
    chk("rst_data_c",  {25'd0, ifc.data_o}, 32'h0);
    reset_n = 1'b1;
    drive(0, 1'b1, 4);

    // 8N1 0xA5: valid one cycle after the stop-bit window, busy drops a cycle later.
    send(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10);
    chk("t1_busy_pre", {31'd0, ifa.busy_o}, 32'h1);
    drive(0, 1'b1, 1);
    chk("t1_valid",    {31'd0, ifa.valid_o}, 32'h1);
    chk("t1_data",     {24'd0, ifa.data_o}, 32'hA5);
    chk("t1_flags",    {29'd0, ifa.parity_err_o, ifa.frame_err_o, ifa.break_o}, 32'h0);
    chk("t1_busy_dn",  {31'd0, ifa.busy_o}, 32'h1);
    drive(0, 1'b1, 1);
    chk("t1_valid_end", {31'd0, ifa.valid_o}, 32'h0);
    chk("t1_busy_end",  {31'd0, ifa.busy_o}, 32'h0);
    chk("t1_data_hold", {24'd0, ifa.data_o}, 32'hA5);

    // 8E1 0x07 (three ones): parity 1 is good, parity 0 is an error.
    send(1, {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    drive(1, 1'b1, 3);
    chk("t2_cnt1", cnt_b, 32'd1);
    chk("t2_data1", {24'd0, data_b}, 32'h07);
    chk("t2_perr1", {31'd0, perr_b}, 32'h0);
    send(1, {5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    drive(1, 1'b1, 3);
    chk("t2_cnt2", cnt_b, 32'd2);
    chk("t2_data2", {24'd0, data_b}, 32'h07);
    chk("t2_perr2", {31'd0, perr_b}, 32'h1);
    chk("t2_ferr2", {31'd0, ferr_b}, 32'h0);

    // 7O2 back-to-back: 0x55 (odd parity bit 1), 0x2A (odd parity bit 0).
    send(2, {5'd0, 2'b11, 1'b1, 7'h55, 1'b0}, 11);
    send(2, {5'd0, 2'b11, 1'b0, 7'h2A, 1'b0}, 11);
    drive(2, 1'b1, 3);
    chk("t3_cnt", cnt_c, 32'd2);
    chk("t3_first", {25'd0, first_c}, 32'h55);
    chk("t3_second", {25'd0, data_c}, 32'h2A);
    chk("t3_perr", {31'd0, perr_c}, 32'h0);
    chk("t3_spacing", tlast_c - tprev_c, 32'd66);
    send(2, {5'd0, 1'b0, 1'b1, 1'b1, 7'h55, 1'b0}, 11);
    drive(2, 1'b1, 20);
    chk("t3_cnt3", cnt_c, 32'd3);
    chk("t3_ferr", {31'd0, ferr_c}, 32'h1);
    chk("t3_brk", {31'd0, brk_c}, 32'h0);
    chk("t3_data3", {25'd0, data_c}, 32'h55);

    // Break: 20 bit times low gives one flagged zero word, then silence until high.
    drive(0, 1'b0, 20 * CPB);
    chk("t4_cnt", cnt_a, 32'd2);
    chk("t4_brk", {31'd0, brk_a}, 32'h1);
    chk("t4_ferr", {31'd0, ferr_a}, 32'h1);
    chk("t4_data", {24'd0, data_a}, 32'h0);
    chk("t4_busy_hold", {31'd0, ifa.busy_o}, 32'h1);
    drive(0, 1'b1, 12);
    chk("t4_cnt_idle", cnt_a, 32'd2);
    chk("t4_busy_idle", {31'd0, ifa.busy_o}, 32'h0);
    send(0, {6'd0, 1'b1, 8'h5A, 1'b0}, 10);
    drive(0, 1'b1, 3);
    chk("t4_cnt_next", cnt_a, 32'd3);
    chk("t4_data_next", {24'd0, data_a}, 32'h5A);
    chk("t4_flags_next", {30'd0, ferr_a, brk_a}, 32'h0);

    // Glitch: two low cycles start a half-bit check that is then rejected.
    drive(0, 1'b0, 2);
    drive(0, 1'b1, 3);
    chk("t5_busy_hw", {31'd0, ifa.busy_o}, 32'h1);
    drive(0, 1'b1, 10);
    chk("t5_busy_idle", {31'd0, ifa.busy_o}, 32'h0);
    chk("t5_cnt", cnt_a, 32'd3);
    send(0, {6'd0, 1'b1, 8'hC3, 1'b0}, 10);
    drive(0, 1'b1, 3);
    chk("t5_cnt_next", cnt_a, 32'd4);
    chk("t5_data_next", {24'd0, data_a}, 32'hC3);

    // Reset mid data bit 4 of 0x81, then a clean 0x3C.
    send(0, {11'd0, 5'b00010}, 5);
    drive(0, 1'b0, 3);
    reset_n = 1'b0;
    drive(0, 1'b1, 3);
    chk("t6_rst_data", {24'd0, ifa.data_o}, 32'h0);
    chk("t6_rst_busy", {31'd0, ifa.busy_o}, 32'h0);
    chk("t6_rst_valid", {31'd0, ifa.valid_o}, 32'h0);
    reset_n = 1'b1;
    drive(0, 1'b1, 20);
    chk("t6_no_word", cnt_a, 32'd4);
    chk("t6_busy", {31'd0, ifa.busy_o}, 32'h0);
    send(0, {6'd0, 1'b1, 8'h3C, 1'b0}, 10);
    drive(0, 1'b1, 3);
    chk("t6_cnt", cnt_a, 32'd5);
    chk("t6_data", {24'd0, data_a}, 32'h3C);
    chk("t6_flags", {29'd0, perr_a, ferr_a, brk_a}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
